// File: rtl/deco_onehot_seq.sv
// Registered one-hot strobe generator with per-request hold and full-output scan; strobe starts one cycle after accept.
// Backpressure: in_ready is low while a hold is mid-pulse or a scan runs; requests offered then are dropped, not queued.
module deco_onehot_seq #(
    parameter int SEL_W     = 4,
    parameter int PULSE_LEN = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        select,
    input  logic                    scan_start,
    output logic                    scan_busy,
    output logic                    out_valid,
    output logic [(1<<SEL_W)-1:0]   decoded_op,
    output logic [SEL_W-1:0]        out_index
);

    localparam int                N_OUT    = 1 << SEL_W;
    localparam logic [7:0]        CNT_LAST = 8'(PULSE_LEN - 1);
    localparam logic [SEL_W-1:0]  IDX_LAST = {SEL_W{1'b1}};
    localparam logic [SEL_W-1:0]  IDX_ONE  = SEL_W'(1);
    localparam logic [N_OUT-1:0]  ONE_HOT0 = {{(N_OUT-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [7:0]         cnt, cnt_nxt;
    logic [SEL_W-1:0]   idx, idx_nxt;
    logic [SEL_W-1:0]   index_nxt;
    logic               last_beat;

    assign last_beat = (cnt == CNT_LAST);
    // Ready in the final hold beat lets the next strobe follow with no bubble.
    assign in_ready  = (state == ST_IDLE) || ((state == ST_HOLD) && last_beat);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        index_nxt = out_index;
        if (in_ready) begin
            if (scan_start) begin
                state_nxt = ST_SCAN;
                cnt_nxt   = '0;
                idx_nxt   = '0;
                index_nxt = '0;
            end else if (in_valid) begin
                state_nxt = ST_HOLD;
                cnt_nxt   = '0;
                index_nxt = select;
            end else begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
                index_nxt = '0;
            end
        end else if (state == ST_HOLD) begin
            cnt_nxt = cnt + 8'd1;
        end else if (state == ST_SCAN) begin
            if (last_beat) begin
                cnt_nxt = '0;
                // The scan stops after the top output; it never wraps.
                if (idx == IDX_LAST) begin
                    state_nxt = ST_IDLE;
                    idx_nxt   = '0;
                    index_nxt = '0;
                end else begin
                    idx_nxt   = idx + IDX_ONE;
                    index_nxt = idx + IDX_ONE;
                end
            end else begin
                cnt_nxt = cnt + 8'd1;
            end
        end else begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            index_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            idx        <= '0;
            out_index  <= '0;
            out_valid  <= 1'b0;
            scan_busy  <= 1'b0;
            decoded_op <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            out_index  <= index_nxt;
            out_valid  <= (state_nxt != ST_IDLE);
            scan_busy  <= (state_nxt == ST_SCAN);
            decoded_op <= (state_nxt != ST_IDLE) ? (ONE_HOT0 << index_nxt) : '0;
        end
    end

endmodule

// File: tb/tb_deco_onehot_seq.sv
// Five parameterisations share one stimulus stream; each is checked every cycle against a queue-based model.
module tb_deco_onehot_seq;

    localparam int ND = 5;
    localparam int P_SEL [ND] = '{4, 4, 4, 3, 5};
    localparam int P_PL  [ND] = '{1, 3, 2, 1, 1};
    localparam int SCAN_LEN [ND] = '{16, 48, 32, 8, 32};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, in_valid, scan_start;
    logic [4:0] select;

    logic [15:0] dec0, dec1, dec2;
    logic [7:0]  dec3;
    logic [31:0] dec4;
    logic [3:0]  oidx0, oidx1, oidx2;
    logic [2:0]  oidx3;
    logic [4:0]  oidx4;
    logic        rdy0, rdy1, rdy2, rdy3, rdy4;
    logic        busy0, busy1, busy2, busy3, busy4;
    logic        ovld0, ovld1, ovld2, ovld3, ovld4;

    deco_onehot_seq #(.SEL_W(4), .PULSE_LEN(1)) u_d0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .select(select[3:0]),
        .scan_start(scan_start), .scan_busy(busy0), .out_valid(ovld0), .decoded_op(dec0), .out_index(oidx0));
    deco_onehot_seq #(.SEL_W(4), .PULSE_LEN(3)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .select(select[3:0]),
        .scan_start(scan_start), .scan_busy(busy1), .out_valid(ovld1), .decoded_op(dec1), .out_index(oidx1));
    deco_onehot_seq #(.SEL_W(4), .PULSE_LEN(2)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .select(select[3:0]),
        .scan_start(scan_start), .scan_busy(busy2), .out_valid(ovld2), .decoded_op(dec2), .out_index(oidx2));
    deco_onehot_seq #(.SEL_W(3), .PULSE_LEN(1)) u_d3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy3), .select(select[2:0]),
        .scan_start(scan_start), .scan_busy(busy3), .out_valid(ovld3), .decoded_op(dec3), .out_index(oidx3));
    deco_onehot_seq #(.SEL_W(5), .PULSE_LEN(1)) u_d4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .select(select[4:0]),
        .scan_start(scan_start), .scan_busy(busy4), .out_valid(ovld4), .decoded_op(dec4), .out_index(oidx4));

    logic [31:0] dec  [ND];
    logic [4:0]  oidx [ND];
    logic        rdy  [ND];
    logic        busy [ND];
    logic        ovld [ND];

    assign dec[0] = 32'(dec0);  assign oidx[0] = 5'(oidx0);  assign rdy[0] = rdy0;  assign busy[0] = busy0;  assign ovld[0] = ovld0;
    assign dec[1] = 32'(dec1);  assign oidx[1] = 5'(oidx1);  assign rdy[1] = rdy1;  assign busy[1] = busy1;  assign ovld[1] = ovld1;
    assign dec[2] = 32'(dec2);  assign oidx[2] = 5'(oidx2);  assign rdy[2] = rdy2;  assign busy[2] = busy2;  assign ovld[2] = ovld2;
    assign dec[3] = 32'(dec3);  assign oidx[3] = 5'(oidx3);  assign rdy[3] = rdy3;  assign busy[3] = busy3;  assign ovld[3] = ovld3;
    assign dec[4] = dec4;       assign oidx[4] = oidx4;      assign rdy[4] = rdy4;  assign busy[4] = busy4;  assign ovld[4] = ovld4;

    // Model: a queue of the strobes still owed after the current cycle.
    typedef struct packed {
        logic       scan;
        logic [4:0] idx;
    } ev_t;

    ev_t q     [ND][$];
    ev_t cur   [ND];
    bit  cur_v [ND];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] act_of(input int d);
        return {busy[d], rdy[d], ovld[d], oidx[d], dec[d]};
    endfunction

    function automatic logic [39:0] exp_of(input int d);
        logic        e_busy;
        logic        e_rdy;
        logic [4:0]  e_idx;
        logic [31:0] e_dec;
        e_busy = cur_v[d] && cur[d].scan;
        e_rdy  = (q[d].size() == 0) && !e_busy;
        e_idx  = cur_v[d] ? cur[d].idx : 5'd0;
        e_dec  = cur_v[d] ? (32'd1 << cur[d].idx) : 32'd0;
        return {e_busy, e_rdy, cur_v[d], e_idx, e_dec};
    endfunction

    task automatic model_edge();
        for (int d = 0; d < ND; d++) begin
            if (rst) begin
                q[d].delete();
                cur_v[d] = 1'b0;
            end else begin
                int  n;
                bit  ready;
                n     = 1 << P_SEL[d];
                ready = (q[d].size() == 0) && !(cur_v[d] && cur[d].scan);
                if (ready) begin
                    if (scan_start) begin
                        for (int i = 0; i < n; i++)
                            for (int j = 0; j < P_PL[d]; j++)
                                q[d].push_back('{scan: 1'b1, idx: 5'(i)});
                    end else if (in_valid) begin
                        for (int j = 0; j < P_PL[d]; j++)
                            q[d].push_back('{scan: 1'b0, idx: 5'(int'(select) % n)});
                    end
                end
                if (q[d].size() > 0) begin
                    cur[d]   = q[d].pop_front();
                    cur_v[d] = 1'b1;
                end else begin
                    cur_v[d] = 1'b0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        for (int d = 0; d < ND; d++)
            chk($sformatf("model_d%0d", d), act_of(d), exp_of(d));
    endtask

    typedef struct {
        logic        vld;
        logic [4:0]  sel;
        logic [15:0] e_dec;
        logic [3:0]  e_idx;
        logic        e_ovld;
    } vec_t;

    vec_t tbl [17];
    int   bcnt [ND];

    initial begin
        for (int i = 0; i < 16; i++) begin
            tbl[i].vld    = 1'b1;
            tbl[i].sel    = 5'(i);
            tbl[i].e_dec  = 16'h0001 << i;
            tbl[i].e_idx  = 4'(i);
            tbl[i].e_ovld = 1'b1;
        end
        tbl[16] = '{vld: 1'b0, sel: 5'd0, e_dec: 16'h0000, e_idx: 4'd0, e_ovld: 1'b0};

        rst = 1'b1; in_valid = 1'b0; scan_start = 1'b0; select = '0;
        for (int d = 0; d < ND; d++) begin
            cur_v[d] = 1'b0;
            cur[d]   = '0;
        end
        step();
        step();
        chk("reset_state", act_of(0), {1'b0, 1'b1, 1'b0, 5'd0, 32'd0});
        rst = 1'b0;
        step();

        // Back-to-back single-cycle strobes on the PULSE_LEN=1 instance.
        for (int i = 0; i < 17; i++) begin
            in_valid = tbl[i].vld;
            select   = tbl[i].sel;
            step();
            chk($sformatf("sweep_%0d", i), 40'({dec0, oidx0, ovld0}),
                40'({tbl[i].e_dec, tbl[i].e_idx, tbl[i].e_ovld}));
        end
        in_valid = 1'b0;
        repeat (4) step();

        // Held pulse on PULSE_LEN=3: a request while not ready is dropped.
        in_valid = 1'b1; select = 5'h0A;
        step();
        chk("held_1", 40'({rdy1, ovld1, dec1}), 40'({1'b0, 1'b1, 16'h0400}));
        select = 5'h03;
        step();
        chk("held_2", 40'({rdy1, ovld1, dec1}), 40'({1'b0, 1'b1, 16'h0400}));
        step();
        chk("held_3", 40'({rdy1, ovld1, dec1}), 40'({1'b1, 1'b1, 16'h0400}));
        step();
        chk("held_4", 40'({rdy1, ovld1, dec1}), 40'({1'b0, 1'b1, 16'h0008}));
        in_valid = 1'b0;
        step();
        chk("held_5", 40'({rdy1, ovld1, dec1}), 40'({1'b0, 1'b1, 16'h0008}));
        step();
        chk("held_6", 40'({rdy1, ovld1, dec1}), 40'({1'b1, 1'b1, 16'h0008}));
        step();
        chk("held_7", 40'({rdy1, ovld1, dec1}), 40'({1'b1, 1'b0, 16'h0000}));
        repeat (4) step();

        // Scan with a simultaneous request (scan wins), plus a request mid-scan.
        scan_start = 1'b1; in_valid = 1'b1; select = 5'd7;
        step();
        scan_start = 1'b0; in_valid = 1'b0;
        for (int d = 0; d < ND; d++) bcnt[d] = 0;
        for (int c = 0; c < 60; c++) begin
            for (int d = 0; d < ND; d++)
                if (busy[d]) bcnt[d]++;
            chk($sformatf("scan2_c%0d", c), 40'({busy2, dec2}),
                40'({(c < 32) ? 1'b1 : 1'b0, (c < 32) ? (16'h0001 << (c / 2)) : 16'h0000}));
            in_valid = (c == 10);
            step();
        end
        in_valid = 1'b0;
        for (int d = 0; d < ND; d++)
            chk($sformatf("scan_len_d%0d", d), 40'(bcnt[d]), 40'(SCAN_LEN[d]));
        repeat (4) step();

        // Reset for two cycles while the PULSE_LEN=1 scan sits at index 5.
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        repeat (5) step();
        chk("pre_rst_idx", 40'({busy0, oidx0}), 40'({1'b1, 4'd5}));
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_mid_scan", act_of(0), {1'b0, 1'b1, 1'b0, 5'd0, 32'd0});
        step();
        chk("after_rst", act_of(0), {1'b0, 1'b1, 1'b0, 5'd0, 32'd0});

        for (int i = 0; i < 3000; i++) begin
            in_valid   = ($urandom_range(1, 0) == 1);
            scan_start = ($urandom_range(49, 0) == 0);
            select     = 5'($urandom);
            rst        = ($urandom_range(299, 0) == 0);
            step();
        end
        rst = 1'b0; in_valid = 1'b0; scan_start = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/deco_onehot_seq.md
# deco_onehot_seq

Registered, handshaked successor to the 4-to-16 combinational decoder in the 19-bit CPU. It converts an `SEL_W`-bit select into a one-hot `2**SEL_W` strobe held for a programmable number of cycles. It also has a scan mode that walks every output in turn, which the CPU uses to clear the register file after reset. It sits between the control unit and the register-file/peripheral write-enable lines.

## Interface
- `SEL_W`, default 4: select width; output width `N_OUT = 2**SEL_W` (derived, not overridable).
- `PULSE_LEN`, default 1: cycles each one-hot strobe is held; legal range 1..255.
- `clk`  in  1: single clock; all state changes on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: request carries a valid `select`.
- `in_ready`  out  1: block can accept a request or scan start this cycle.
- `select`  in  SEL_W: index of the output to strobe.
- `scan_start`  in  1: begin a full scan of all outputs.
- `scan_busy`  out  1: scan in progress.
- `out_valid`  out  1: `decoded_op` carries a live strobe.
- `decoded_op`  out  N_OUT: one-hot strobe, all-zero when `out_valid`=0.
- `out_index`  out  SEL_W: binary index of the active strobe, 0 when idle.

## Operation
- States: IDLE, HOLD, SCAN. A hold counter `cnt` runs 0..PULSE_LEN-1. A scan index `idx` runs 0..N_OUT-1.
- Reset (`rst`=1 at an edge):
  - State goes to IDLE; `cnt`=0, `idx`=0.
  - `decoded_op`=0, `out_valid`=0, `out_index`=0, `scan_busy`=0, `in_ready`=1 (after the edge).
  - Reset overrides any request or scan in the same cycle and aborts HOLD/SCAN mid-operation; no further strobes appear.
- `in_ready` = (state==IDLE) or (state==HOLD and cnt==PULSE_LEN-1). It is combinational from state only, never from `in_valid`.
- Accept rules, evaluated when `in_ready`=1:
  - `scan_start`=1: go to SCAN with idx=0, cnt=0. `in_valid` in the same cycle is dropped (scan has priority).
  - Otherwise `in_valid`=1: go to HOLD, `out_index`<=`select`, `decoded_op`<=1<<`select`, cnt<=0.
  - Neither: the last cycle of HOLD returns to IDLE.
- HOLD: `out_valid`=1 and `decoded_op` stays constant. `cnt` increments each cycle until PULSE_LEN-1.
- SCAN:
  - `scan_busy`=1, `out_valid`=1, `in_ready`=0, `decoded_op`=1<<idx, `out_index`=idx.
  - Each index is held PULSE_LEN cycles, then idx increments.
  - After idx=N_OUT-1 completes its hold, go to IDLE. No wrap to 0.
  - `scan_start` and `in_valid` are ignored during SCAN.
- Invariant: `decoded_op` has zero or exactly one bit set; it is non-zero iff `out_valid`=1.

## Timing
- Request latency: a request accepted at edge k drives its strobe from cycle k+1 through k+PULSE_LEN inclusive.
- Back-to-back requests:
  - A request accepted in the last HOLD cycle drives its strobe starting the very next cycle. There are no bubbles between strobes.
  - With PULSE_LEN=1, one request is sustained per cycle.
- Scan duration:
  - `scan_start` accepted at edge k gives `scan_busy` high for cycles k+1 .. k+N_OUT*PULSE_LEN.
  - `in_ready` returns to 1 in cycle k+N_OUT*PULSE_LEN+1.
- All outputs are registered except `in_ready`. There is no combinational path from `select`, `in_valid` or `scan_start` to any output.

## Test plan
- Reset values:
  - Assert `rst` 2 cycles mid-scan (SEL_W=4, PULSE_LEN=1, idx=5).
  - Required: the next cycle has `decoded_op`=16'h0000, `out_valid`=0, `scan_busy`=0, `in_ready`=1, `out_index`=0.
- Single requests:
  - PULSE_LEN=1; drive `select`=0..F, one per cycle, with `in_valid` held high.
  - Required: `decoded_op` = 16'h0001, 16'h0002, … 16'h8000 on consecutive cycles, each one cycle after its request, with `out_index` matching.
- Held pulse:
  - PULSE_LEN=3; request `select`=4'hA, then `select`=4'h3 while `in_ready` is low, then again when `in_ready` is high.
  - Required: 16'h0400 held exactly 3 cycles; `in_ready` high only in the third; 16'h0008 follows with no gap; the low-ready request is not taken.
- Full scan:
  - PULSE_LEN=2; assert `scan_start` in IDLE.
  - Required: `scan_busy` high for 32 cycles; each bit from 16'h0001 to 16'h8000 is held 2 cycles; then IDLE with `decoded_op`=0 and no wrap.
- Priority and ignore:
  - `scan_start` and `in_valid` (`select`=7) in the same IDLE cycle.
  - Required: scan runs and bit 7 is not strobed separately.
  - `in_valid` pulsed during SCAN produces no extra strobe.
- Width generalisation:
  - Instantiate SEL_W=3 and SEL_W=5; sweep all selects.
  - Required: outputs of width 8 and 32 respectively, each exactly one-hot at the index `select`, and the scan lasts 8 and 32 cycles respectively (PULSE_LEN=1).
